// File: rtl/multiplier_n_bit_seq_v_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and counter sizing live here so every file agrees.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/multiplier_n_bit_seq_v_if.sv
// Request/result bundle of the sequential multiplier.
// The requester drives the i_* side and observes the o_* side.
interface multiplier_n_bit_seq_v_if #(
    parameter int WIDTH = 4
);
    import mult_pkg::*;

    logic               i_start;
    logic               i_signed;
    logic [WIDTH-1:0]   i_a;
    logic [WIDTH-1:0]   i_b;
    logic               o_busy;
    logic               o_done;
    logic [2*WIDTH-1:0] o_f;

    modport master (
        output i_start, i_signed, i_a, i_b,
        input  o_busy, o_done, o_f
    );

    modport slave (
        input  i_start, i_signed, i_a, i_b,
        output o_busy, o_done, o_f
    );

endinterface

// File: rtl/multiplier_n_bit_seq_v_abs.sv
// Conditional two's-complement negate; used both for operand
// magnitudes and for restoring the sign of the product.
module twos_comp_abs_v #(
    parameter int WIDTH = 4
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + 1'b1) : x;

endmodule

// File: rtl/multiplier_n_bit_seq_v.sv
// Multi-cycle radix-2 shift-add multiplier, signed or unsigned,
// with a start/busy/done handshake and a held product register.
module multiplier_n_bit_seq_v
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    multiplier_n_bit_seq_v_if.slave bus
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [2*WIDTH-1:0]   f;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;
    logic                 sign;
    logic                 done;
    logic                 load;
    logic                 step;
    logic                 last;

    twos_comp_abs_v #(.WIDTH(WIDTH)) u_abs_a (
        .neg (bus.i_signed & bus.i_a[WIDTH-1]),
        .x   (bus.i_a),
        .y   (a_mag)
    );

    twos_comp_abs_v #(.WIDTH(WIDTH)) u_abs_b (
        .neg (bus.i_signed & bus.i_b[WIDTH-1]),
        .x   (bus.i_b),
        .y   (b_mag)
    );

    // Upper half keeps the carry so the shift never loses a bit.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};

    twos_comp_abs_v #(.WIDTH(2*WIDTH)) u_neg (
        .neg (sign),
        .x   (acc_step),
        .y   (prod_fix)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            sign  <= 1'b0;
            f     <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                cnt   <= '0;
                acc   <= {{WIDTH{1'b0}}, b_mag};
                mcand <= a_mag;
                sign  <= bus.i_signed
                       & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
            end else if (step) begin
                cnt <= cnt + 1'b1;
                acc <= acc_step;
                if (last) begin
                    f <= prod_fix;
                end
            end
        end
    end

    assign bus.o_busy = (state == RUN);
    assign bus.o_done = done;
    assign bus.o_f    = f;

endmodule
